bcd_display_formatter: RTL and testbench
========================================

Name: bcd_display_formatter

Overview:
Sequential formatter that sits directly upstream of display_controller. It turns a binary register value (e.g. R1 from the core) into the 4-digit nibble word the 7-segment multiplexer displays. In hex mode the value passes through. In decimal mode an iterative double-dabble converter produces packed BCD. A valid/ready handshake on the input and a one-cycle valid pulse on the output let the top level re-sample at its own refresh rate, typically from a clock_divider tick.

Parameters:
IN_WIDTH, 16, width of the binary input value (1..32)
DIGITS, 4, number of output digits; value_out is 4*DIGITS bits

Ports:
clk  input  1  system clock; all state updates on the rising edge
reset  input  1  synchronous, active-high reset
value_in  input  IN_WIDTH  binary value to format
mode_dec  input  1  1 = decimal (BCD) output, 0 = hex passthrough
valid_in  input  1  request to format value_in; sampled only when ready_out=1
ready_out  output  1  high only in IDLE; a request is accepted on an edge where valid_in&&ready_out
value_out  output  4*DIGITS  formatted nibbles, digit 0 in [3:0]; held between results
valid_out  output  1  one-cycle pulse; high in the cycle value_out carries a new result
overflow  output  1  registered with value_out; 1 = value not representable, output saturated
busy  output  1  high in CONVERT and DONE (equals ~ready_out)

Behaviour:
- Interface: one clock; reset is synchronous and active-high. The clock port is clk and the reset port is reset.
- Reset: state=IDLE, value_out=0, overflow=0, valid_out=0, busy=0, ready_out=1. All internal shift registers are cleared.
- Reset mid-conversion aborts the conversion. value_out returns to 0 and no valid_out pulse is produced.
- States: IDLE, CONVERT, DONE.
- IDLE: on an accepting edge E0, capture value_in and mode_dec into internal registers. Later changes on the inputs are ignored.
  - Hex mode: the result is value_in zero-extended or truncated to 4*DIGITS bits. overflow=1 iff any bit of value_in at or above bit 4*DIGITS is set; in that case the result is all nibbles 0xF. Go to DONE.
  - Decimal mode: if value_in > 10^DIGITS-1, the result is all nibbles 0x9 and overflow=1; go to DONE.
  - Otherwise load bin=value_in, bcd=0, cnt=0, and go to CONVERT.
- CONVERT: one double-dabble step per cycle.
  - First, every BCD digit >= 5 gets +3 (all digits in parallel, from the same pre-add values).
  - Then {bcd,bin} shifts left by 1 and cnt increments.
  - After exactly IN_WIDTH steps, go to DONE with result=bcd and overflow=0.
- DONE (lasts exactly one cycle):
  - value_out and overflow are updated on the edge that enters DONE.
  - valid_out=1 for that cycle.
  - Next state is IDLE; ready_out rises on the following edge.
- Latency, measured as the number of edges from the accepting edge E0 to the edge that asserts valid_out:
  - Hex or overflow path: 1 edge.
  - Decimal path: IN_WIDTH+1 edges (17 at the defaults).
- Throughput: at most one request per 3 cycles (hex) or IN_WIDTH+3 cycles (decimal).
- valid_in while busy=1 is ignored. There is no queueing and no effect on the conversion in flight.
- value_in=0 in decimal mode still runs the full IN_WIDTH steps and yields 0.
- value_out never glitches mid-conversion: the working bcd register is separate from value_out.
- The BCD working register is 4*DIGITS bits. The pre-check guarantees no carry out of the top digit.
- The 10^DIGITS-1 constant is computed at elaboration.

Test Plan:
- Reset, then decimal request value_in=16'd1234, mode_dec=1 -> valid_out pulses exactly 17 edges after accept; value_out=16'h1234, overflow=0; ready_out high 1 cycle later.
- Hex request value_in=16'hBEEF, mode_dec=0 -> valid_out pulses 1 edge after accept; value_out=16'hBEEF, overflow=0.
- Decimal 16'd10000 -> after 1 edge value_out=16'h9999, overflow=1. Decimal 16'd9999 -> after 17 edges value_out=16'h9999, overflow=0. Decimal 0 -> after 17 edges value_out=16'h0000.
- Accept 16'd4321. During CONVERT, drive valid_in=1 with value_in=16'd55 and toggle mode_dec -> exactly one valid_out pulse with value_out=16'h4321; the second request is not accepted.
- Accept 16'd777, assert reset for 1 cycle at step 8, release -> value_out=0, valid_out never pulses, ready_out=1 on the edge after reset. A new request for 16'd42 then yields 16'h0042.
- Back-to-back: hold valid_in=1 with alternating 16'd59/16'h00AB hex/decimal -> every result is correct, and accepts are spaced by the exact latency plus 2 cycles.

Source files
------------

// File: rtl/bcd_display_formatter.sv
// Binary-to-display formatter: hex passthrough or iterative double-dabble BCD,
// with a valid/ready request handshake and a one-cycle result pulse.
module bcd_display_formatter #(
    parameter int unsigned IN_WIDTH = 16,
    parameter int unsigned DIGITS   = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic [IN_WIDTH-1:0]   value_in,
    input  logic                  mode_dec,
    input  logic                  valid_in,
    output logic                  ready_out,
    output logic [4*DIGITS-1:0]   value_out,
    output logic                  valid_out,
    output logic                  overflow,
    output logic                  busy
);

    localparam int unsigned OUT_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(IN_WIDTH + 1);
    localparam int unsigned EXT_W = (IN_WIDTH > OUT_W) ? IN_WIDTH : OUT_W;

    // Largest value representable in DIGITS decimal digits.
    function automatic logic [63:0] dec_max_f(input int unsigned d);
        logic [63:0] p;
        p = 64'd1;
        for (int unsigned i = 0; i < d; i++) begin
            p = p * 64'd10;
        end
        return p - 64'd1;
    endfunction

    localparam logic [63:0] DEC_MAX = dec_max_f(DIGITS);

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_CONVERT = 2'd1,
        S_DONE    = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nx;

    logic                  accept;
    logic [EXT_W-1:0]      in_ext;
    logic                  hex_ovf;
    logic                  dec_ovf;
    logic                  last_step;
    logic [IN_WIDTH-1:0]   bin;
    logic [OUT_W-1:0]      bcd;
    logic [OUT_W-1:0]      bcd_adj;
    logic [OUT_W-1:0]      bcd_step;
    logic [CNT_W-1:0]      cnt;
    logic                  ovf_q;

    assign accept    = valid_in && (state == S_IDLE);
    assign in_ext    = EXT_W'(value_in);
    assign hex_ovf   = |(in_ext >> OUT_W);
    assign dec_ovf   = 64'(value_in) > DEC_MAX;
    assign last_step = (cnt == CNT_W'(IN_WIDTH));

    // Add-3 correction: every digit judged from the same pre-add value.
    always_comb begin
        bcd_adj = bcd;
        for (int d = 0; d < int'(DIGITS); d++) begin
            if (bcd[4*d +: 4] >= 4'd5) begin
                bcd_adj[4*d +: 4] = bcd[4*d +: 4] + 4'd3;
            end
        end
    end

    assign bcd_step = {bcd_adj[OUT_W-2:0], bin[IN_WIDTH-1]};

    always_ff @(posedge clk) begin
        if (reset) begin
            state <= S_IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            S_IDLE:    if (accept)    state_nx = S_CONVERT;
            S_CONVERT: if (last_step) state_nx = S_DONE;
            S_DONE:                   state_nx = S_IDLE;
            default:                  state_nx = S_IDLE;
        endcase
    end

    always_comb begin
        ready_out = 1'b0;
        busy      = 1'b0;
        valid_out = 1'b0;
        ready_out = (state == S_IDLE);
        busy      = (state != S_IDLE);
        valid_out = (state == S_DONE);
    end

    // Hex and saturated results are staged in bcd with cnt preloaded to its
    // terminal count, so every request leaves through the same CONVERT->DONE edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            bin       <= '0;
            bcd       <= '0;
            cnt       <= '0;
            ovf_q     <= 1'b0;
            value_out <= '0;
            overflow  <= 1'b0;
        end else begin
            unique case (state)
                S_IDLE: begin
                    if (accept) begin
                        bin <= value_in;
                        if (!mode_dec) begin
                            bcd   <= hex_ovf ? '1 : OUT_W'(value_in);
                            ovf_q <= hex_ovf;
                            cnt   <= CNT_W'(IN_WIDTH);
                        end else if (dec_ovf) begin
                            bcd   <= {DIGITS{4'h9}};
                            ovf_q <= 1'b1;
                            cnt   <= CNT_W'(IN_WIDTH);
                        end else begin
                            bcd   <= '0;
                            ovf_q <= 1'b0;
                            cnt   <= '0;
                        end
                    end
                end
                S_CONVERT: begin
                    if (last_step) begin
                        value_out <= bcd;
                        overflow  <= ovf_q;
                    end else begin
                        bcd <= bcd_step;
                        bin <= bin << 1;
                        cnt <= cnt + 1'b1;
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_bcd_display_formatter.sv
// Directed bench for bcd_display_formatter at default parameters (16-bit in, 4 digits).
module tb_bcd_display_formatter;

    logic        clk;
    logic        reset;
    logic [15:0] value_in;
    logic        mode_dec;
    logic        valid_in;
    logic        ready_out;
    logic [15:0] value_out;
    logic        valid_out;
    logic        overflow;
    logic        busy;

    int vectors    = 0;
    int miscompares = 0;
    int pulse_cnt  = 0;

    bcd_display_formatter #(.IN_WIDTH(16), .DIGITS(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .value_in  (value_in),
        .mode_dec  (mode_dec),
        .valid_in  (valid_in),
        .ready_out (ready_out),
        .value_out (value_out),
        .valid_out (valid_out),
        .overflow  (overflow),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (valid_out === 1'b1) pulse_cnt++;
    end

    task automatic wait_ready();
        int guard;
        guard = 0;
        while (ready_out !== 1'b1 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        if (guard >= 50) begin
            vectors++; miscompares++;
            $display("FAIL wait_ready: ready_out=%b required 1 within 50 cycles", ready_out);
        end
    endtask

    // Issue one request and return edges from accept to the valid_out edge.
    task automatic do_request(input logic [15:0] v, input logic dec,
                              output int lat, output logic [15:0] vo, output logic ovf);
        wait_ready();
        value_in = v; mode_dec = dec; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        lat = -1; vo = 'x; ovf = 1'bx;
        for (int i = 1; i <= 60; i++) begin
            @(posedge clk); #1;
            if (valid_out === 1'b1) begin
                lat = i; vo = value_out; ovf = overflow;
                break;
            end
        end
    endtask

    task automatic test_reset();
        reset = 1'b1; valid_in = 1'b0; value_in = '0; mode_dec = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        vectors++; if (value_out !== 16'h0000) begin miscompares++; $display("FAIL reset_value: got %h want 0000", value_out); end
        vectors++; if (overflow !== 1'b0) begin miscompares++; $display("FAIL reset_overflow: got %b want 0", overflow); end
        vectors++; if (valid_out !== 1'b0) begin miscompares++; $display("FAIL reset_valid: got %b want 0", valid_out); end
        vectors++; if (busy !== 1'b0) begin miscompares++; $display("FAIL reset_busy: got %b want 0", busy); end
        vectors++; if (ready_out !== 1'b1) begin miscompares++; $display("FAIL reset_ready: got %b want 1", ready_out); end
        reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_decimal();
        int lat; logic [15:0] vo; logic ovf;
        do_request(16'd1234, 1'b1, lat, vo, ovf);
        vectors++; if (lat != 17) begin miscompares++; $display("FAIL dec1234_latency: got %0d want 17", lat); end
        vectors++; if (vo !== 16'h1234) begin miscompares++; $display("FAIL dec1234_value: got %h want 1234", vo); end
        vectors++; if (ovf !== 1'b0) begin miscompares++; $display("FAIL dec1234_overflow: got %b want 0", ovf); end
        vectors++; if (busy !== 1'b1 || ready_out !== 1'b0) begin miscompares++; $display("FAIL done_busy: busy=%b ready=%b want 1/0", busy, ready_out); end
        @(posedge clk); #1;
        vectors++; if (ready_out !== 1'b1 || valid_out !== 1'b0) begin miscompares++; $display("FAIL after_done: ready=%b valid=%b want 1/0", ready_out, valid_out); end
        vectors++; if (value_out !== 16'h1234) begin miscompares++; $display("FAIL held_value: got %h want 1234", value_out); end

        do_request(16'd9999, 1'b1, lat, vo, ovf);
        vectors++; if (lat != 17 || vo !== 16'h9999 || ovf !== 1'b0) begin miscompares++; $display("FAIL dec9999: lat=%0d val=%h ovf=%b want 17/9999/0", lat, vo, ovf); end
        do_request(16'd10000, 1'b1, lat, vo, ovf);
        vectors++; if (lat != 1 || vo !== 16'h9999 || ovf !== 1'b1) begin miscompares++; $display("FAIL dec10000_sat: lat=%0d val=%h ovf=%b want 1/9999/1", lat, vo, ovf); end
        do_request(16'd0, 1'b1, lat, vo, ovf);
        vectors++; if (lat != 17 || vo !== 16'h0000 || ovf !== 1'b0) begin miscompares++; $display("FAIL dec0: lat=%0d val=%h ovf=%b want 17/0000/0", lat, vo, ovf); end
        do_request(16'd65535, 1'b1, lat, vo, ovf);
        vectors++; if (lat != 1 || vo !== 16'h9999 || ovf !== 1'b1) begin miscompares++; $display("FAIL dec65535_sat: lat=%0d val=%h ovf=%b want 1/9999/1", lat, vo, ovf); end
        do_request(16'd5678, 1'b1, lat, vo, ovf);
        vectors++; if (lat != 17 || vo !== 16'h5678 || ovf !== 1'b0) begin miscompares++; $display("FAIL dec5678: lat=%0d val=%h ovf=%b want 17/5678/0", lat, vo, ovf); end
    endtask

    task automatic test_hex();
        int lat; logic [15:0] vo; logic ovf;
        do_request(16'hBEEF, 1'b0, lat, vo, ovf);
        vectors++; if (lat != 1) begin miscompares++; $display("FAIL hex_latency: got %0d want 1", lat); end
        vectors++; if (vo !== 16'hBEEF || ovf !== 1'b0) begin miscompares++; $display("FAIL hex_beef: val=%h ovf=%b want beef/0", vo, ovf); end
        do_request(16'd10000, 1'b0, lat, vo, ovf);
        vectors++; if (lat != 1 || vo !== 16'h2710 || ovf !== 1'b0) begin miscompares++; $display("FAIL hex_2710: lat=%0d val=%h ovf=%b want 1/2710/0", lat, vo, ovf); end
    endtask

    task automatic test_busy_ignore();
        int lat; int p0; logic [15:0] vo; logic ovf;
        wait_ready();
        value_in = 16'd4321; mode_dec = 1'b1; valid_in = 1'b1;
        @(posedge clk); #1;
        value_in = 16'd55;
        p0 = pulse_cnt; lat = -1; vo = 'x; ovf = 1'bx;
        for (int i = 1; i <= 60; i++) begin
            mode_dec = ~mode_dec;
            @(posedge clk); #1;
            if (valid_out === 1'b1) begin
                lat = i; vo = value_out; ovf = overflow;
                valid_in = 1'b0;
                break;
            end
        end
        valid_in = 1'b0;
        vectors++; if (lat != 17 || vo !== 16'h4321 || ovf !== 1'b0) begin miscompares++; $display("FAIL busy_ignore_result: lat=%0d val=%h ovf=%b want 17/4321/0", lat, vo, ovf); end
        repeat (4) @(posedge clk);
        #1;
        vectors++; if (pulse_cnt - p0 != 1) begin miscompares++; $display("FAIL busy_ignore_pulses: got %0d want 1", pulse_cnt - p0); end
        vectors++; if (ready_out !== 1'b1 || value_out !== 16'h4321) begin miscompares++; $display("FAIL busy_ignore_idle: ready=%b val=%h want 1/4321", ready_out, value_out); end
    endtask

    task automatic test_reset_abort();
        int lat; int p0; logic [15:0] vo; logic ovf;
        wait_ready();
        value_in = 16'd777; mode_dec = 1'b1; valid_in = 1'b1;
        @(posedge clk); #1;
        valid_in = 1'b0;
        p0 = pulse_cnt;
        repeat (8) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        reset = 1'b0;
        vectors++; if (value_out !== 16'h0000 || overflow !== 1'b0) begin miscompares++; $display("FAIL abort_value: val=%h ovf=%b want 0000/0", value_out, overflow); end
        vectors++; if (ready_out !== 1'b1 || busy !== 1'b0 || valid_out !== 1'b0) begin miscompares++; $display("FAIL abort_state: ready=%b busy=%b valid=%b want 1/0/0", ready_out, busy, valid_out); end
        repeat (20) @(posedge clk);
        #1;
        vectors++; if (pulse_cnt != p0) begin miscompares++; $display("FAIL abort_no_pulse: got %0d pulses want 0", pulse_cnt - p0); end
        do_request(16'd42, 1'b1, lat, vo, ovf);
        vectors++; if (lat != 17 || vo !== 16'h0042 || ovf !== 1'b0) begin miscompares++; $display("FAIL after_abort_42: lat=%0d val=%h ovf=%b want 17/0042/0", lat, vo, ovf); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] req_v   [4];
        logic        req_d   [4];
        logic [15:0] exp_v   [4];
        int          exp_lat [4];
        int          acc_at  [4];
        int          res_at  [4];
        logic [15:0] res_v   [4];
        int n; int k_acc; int k_res; logic rdy_b; logic vin_b;
        req_v[0] = 16'd59;   req_d[0] = 1'b0; exp_v[0] = 16'h003B; exp_lat[0] = 1;
        req_v[1] = 16'h00AB; req_d[1] = 1'b1; exp_v[1] = 16'h0171; exp_lat[1] = 17;
        req_v[2] = 16'd59;   req_d[2] = 1'b1; exp_v[2] = 16'h0059; exp_lat[2] = 17;
        req_v[3] = 16'h00AB; req_d[3] = 1'b0; exp_v[3] = 16'h00AB; exp_lat[3] = 1;
        for (int i = 0; i < 4; i++) begin acc_at[i] = -100; res_at[i] = -100; res_v[i] = 'x; end
        wait_ready();
        value_in = req_v[0]; mode_dec = req_d[0]; valid_in = 1'b1;
        n = 0; k_acc = 0; k_res = 0;
        while (k_res < 4 && n < 200) begin
            rdy_b = ready_out; vin_b = valid_in;
            @(posedge clk); #1;
            n++;
            if (rdy_b && vin_b && k_acc < 4) begin
                acc_at[k_acc] = n;
                k_acc++;
                if (k_acc < 4) begin value_in = req_v[k_acc]; mode_dec = req_d[k_acc]; end
                else valid_in = 1'b0;
            end
            if (valid_out === 1'b1) begin
                res_at[k_res] = n; res_v[k_res] = value_out;
                k_res++;
            end
        end
        valid_in = 1'b0;
        for (int i = 0; i < 4; i++) begin
            vectors++;
            if (res_v[i] !== exp_v[i] || res_at[i] - acc_at[i] != exp_lat[i]) begin
                miscompares++;
                $display("FAIL b2b_result[%0d]: val=%h lat=%0d want %h/%0d", i, res_v[i], res_at[i] - acc_at[i], exp_v[i], exp_lat[i]);
            end
        end
        for (int i = 0; i < 3; i++) begin
            vectors++;
            if (acc_at[i+1] - acc_at[i] != exp_lat[i] + 2) begin
                miscompares++;
                $display("FAIL b2b_spacing[%0d]: got %0d want %0d", i, acc_at[i+1] - acc_at[i], exp_lat[i] + 2);
            end
        end
    endtask

    initial begin
        reset = 1'b1; valid_in = 1'b0; value_in = '0; mode_dec = 1'b0;
        test_reset();
        test_decimal();
        test_hex();
        test_busy_ignore();
        test_reset_abort();
        test_back_to_back();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
